johnson_monitor: RTL and testbench

Sequential decoder and checker for the 4-bit Johnson counter output. It samples the counter's `q` bus and decodes each Johnson code to a 3-bit binary count. It checks that every sample is a legal code and a legal step, and tracks lock and fault state. It sits beside the counter under test, on the read side of the same `q` interface that the counter drives.

---
 rtl/johnson_monitor.sv | 177 +++++++++++++++++
 tb/tb_johnson_monitor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/johnson_monitor.sv
// johnson_monitor: decodes a 4-bit Johnson code to a 3-bit count, checks
// every sampled code for legality and every step for +1 progress, and tracks
// lock/fault state with a saturating error counter.
// Optional feature macro: JMON_WRAP_CNT_EN adds the `wraps` port and counter.
module johnson_monitor #(
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
`ifdef JMON_WRAP_CNT_EN
  ,
  parameter int WRAP_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [3:0]       q,
  output logic [2:0]       count,
  output logic             code_valid,
  output logic             locked,
  output logic             fault,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
`ifdef JMON_WRAP_CNT_EN
  ,
  output logic [WRAP_W-1:0] wraps
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_N);

  state_e           state_q, state_d;
  logic [2:0]       count_q, count_d;     // also serves as the previous legal sample
  logic             valid_q, valid_d;
  logic [3:0]       good_q, good_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             dec_legal;
  logic [2:0]       dec_val;
  logic             step_good;
  logic             step_hold;
  logic             lock_reach;

  // Decode the Johnson code; the eight non-Johnson patterns are illegal.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
    dec_legal = 1'b1;
    dec_val   = 3'd0;
    case (q)
      4'b0000: dec_val = 3'd0;
      4'b0001: dec_val = 3'd1;
      4'b0011: dec_val = 3'd2;
      4'b0111: dec_val = 3'd3;
      4'b1111: dec_val = 3'd4;
      4'b1110: dec_val = 3'd5;
      4'b1100: dec_val = 3'd6;
      4'b1000: dec_val = 3'd7;
      default: dec_legal = 1'b0;
    endcase
  end

  // Step classification against the previous legal sample (3-bit add wraps 7->0).
  assign step_good  = dec_legal && (dec_val == count_q + 3'd1);
  assign step_hold  = dec_legal && (dec_val == count_q);
  assign lock_reach = (good_q + 4'd1) == LOCK_CNT;

  // Next-state logic for the lock FSM, decoded count and error counter.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    valid_d   = valid_q;
    good_d    = good_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      state_d   = ST_IDLE;
      count_d   = 3'd0;
      valid_d   = 1'b0;
      good_d    = 4'd0;
      err_cnt_d = '0;
    end else if (en) begin
      valid_d = dec_legal;
      if (dec_legal) count_d = dec_val;
      case (state_q)
        ST_IDLE: begin
          if (dec_legal) begin
            state_d = ST_TRACK;
            good_d  = 4'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_TRACK: begin
          if (!dec_legal) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else if (step_good) begin
            good_d = good_q + 4'd1;
            if (lock_reach) state_d = ST_LOCKED;
          end else if (!step_hold) begin
            good_d = 4'd0;
            err_d  = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!(step_good || step_hold)) begin
            state_d = ST_FAULT;
            err_d   = 1'b1;
          end
        end
        default: begin
          // FAULT is sticky; only illegal codes still report errors.
          if (!dec_legal) err_d = 1'b1;
        end
      endcase
      if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments so every flop captures pre-edge values regardless of statement order.
      state_q   <= ST_IDLE;
      count_q   <= 3'd0;
      valid_q   <= 1'b0;
      good_q    <= 4'd0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      good_q    <= good_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef JMON_WRAP_CNT_EN
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic              wrap_hit;

  // A good 7->0 step counts only while locked, including the locking sample.
  always_comb begin
    wrap_hit = en && !clr && step_good && (count_q == 3'd7) &&
               ((state_q == ST_LOCKED) || ((state_q == ST_TRACK) && lock_reach));
    wraps_d  = wraps_q;
    if (clr)           wraps_d = '0;
    else if (wrap_hit) wraps_d = wraps_q + WRAP_W'(1);
  end

  // Wrap counter register; rolls over modulo 2^WRAP_W.
  always_ff @(posedge clk) begin
    if (rst) wraps_q <= '0;
    else     wraps_q <= wraps_d;
  end

  assign wraps = wraps_q;
`endif

  assign count      = count_q;
  assign code_valid = valid_q;
  assign locked     = (state_q == ST_LOCKED);
  assign fault      = (state_q == ST_FAULT);
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_johnson_monitor.sv
// tb_johnson_monitor: directed vectors with hand-computed expectations pushed
// into a scoreboard queue; a separate monitor pops and compares every cycle.
// A second instance with ERR_W=2 shares the stimulus to show saturation.
module tb_johnson_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       en  = 1'b0;
  logic [3:0] q   = 4'b0000;

  logic [2:0] count, count2;
  logic       code_valid, code_valid2;
  logic       locked, locked2;
  logic       fault, fault2;
  logic       err, err2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
`ifdef JMON_WRAP_CNT_EN
  logic [7:0] wraps, wraps2;
`endif

  always #5 clk = ~clk;

  johnson_monitor #(.LOCK_N(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .q(q),
    .count(count), .code_valid(code_valid), .locked(locked), .fault(fault),
    .err(err), .err_cnt(err_cnt)
`ifdef JMON_WRAP_CNT_EN
    , .wraps(wraps)
`endif
  );

  johnson_monitor #(.LOCK_N(4), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .q(q),
    .count(count2), .code_valid(code_valid2), .locked(locked2), .fault(fault2),
    .err(err2), .err_cnt(err_cnt2)
`ifdef JMON_WRAP_CNT_EN
    , .wraps(wraps2)
`endif
  );

  typedef struct {
    int   count;
    logic valid;
    logic locked;
    logic fault;
    logic err;
    int   ec;
    int   wraps;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] jc [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                         4'b1111, 4'b1110, 4'b1100, 4'b1000};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after that edge.
  task automatic step(input logic r, input logic c, input logic e, input logic [3:0] qv,
                      input int cnt, input logic v, input logic l, input logic f,
                      input logic er, input int ec, input int wr);
    exp_t x;
    @(negedge clk);
    rst = r; clr = c; en = e; q = qv;
    x.count = cnt; x.valid = v; x.locked = l; x.fault = f;
    x.err = er; x.ec = ec; x.wraps = wr;
    sb_q.push_back(x);
  endtask

  // Monitor: compare DUT outputs just after each edge against the queued entry.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("count",      int'(count),      x.count);
        check("code_valid", int'(code_valid), int'(x.valid));
        check("locked",     int'(locked),     int'(x.locked));
        check("fault",      int'(fault),      int'(x.fault));
        check("err",        int'(err),        int'(x.err));
        check("err_cnt",    int'(err_cnt),    x.ec);
        check("err_cnt_w2", int'(err_cnt2),   (x.ec > 3) ? 3 : x.ec);
`ifdef JMON_WRAP_CNT_EN
        check("wraps",      int'(wraps),      x.wraps);
`endif
      end
    end
  end

  initial begin
    int wr;
    int v;
    // Reset state.
    step(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 4'b0101, 0, 0, 0, 0, 0, 0, 0);

    // Lock sequence: first legal sample plus four good steps.
    step(0, 0, 1, jc[0], 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, jc[1], 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, jc[2], 2, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, jc[3], 3, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, jc[4], 4, 1, 1, 0, 0, 0, 0);

    // Sixteen further good samples, crossing 7->0 twice.
    wr = 0;
    for (int i = 1; i <= 16; i++) begin
      v = (4 + i) % 8;
      if (v == 0) wr++;
      step(0, 0, 1, jc[v], v, 1, 1, 0, 0, 0, wr);
    end

    // Illegal code while locked -> fault; en=0 drops err; fault is sticky; clr.
    step(0, 0, 1, 4'b0101, 4, 0, 0, 1, 1, 1, 2);
    step(0, 0, 0, 4'b1010, 4, 0, 0, 1, 0, 1, 2);
    step(0, 0, 1, jc[5],   5, 1, 0, 1, 0, 1, 2);
    step(0, 0, 1, jc[6],   6, 1, 0, 1, 0, 1, 2);
    step(0, 1, 1, jc[7],   0, 0, 0, 0, 0, 0, 0);

    // Skip in TRACK restarts the good count, then four good steps lock.
    step(0, 0, 1, jc[0], 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, jc[1], 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, jc[3], 3, 1, 0, 0, 1, 1, 0);
    step(0, 0, 1, jc[4], 4, 1, 0, 0, 0, 1, 0);
    step(0, 0, 1, jc[5], 5, 1, 0, 0, 0, 1, 0);
    step(0, 0, 1, jc[6], 6, 1, 0, 0, 0, 1, 0);
    step(0, 0, 1, jc[7], 7, 1, 1, 0, 0, 1, 0);

    // Advance to 2 while locked (one wrap), then hold 0011 repeatedly.
    step(0, 0, 1, jc[0], 0, 1, 1, 0, 0, 1, 1);
    step(0, 0, 1, jc[1], 1, 1, 1, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, jc[2], 2, 1, 1, 0, 0, 1, 1);

    // en=0 with garbage: nothing moves. Then a good step.
    step(0, 0, 0, 4'b0101, 2, 1, 1, 0, 0, 1, 1);
    step(0, 0, 0, 4'b1010, 2, 1, 1, 0, 0, 1, 1);
    step(0, 0, 0, jc[6],   2, 1, 1, 0, 0, 1, 1);
    step(0, 0, 1, jc[3],   3, 1, 1, 0, 0, 1, 1);

    // Reset, then illegal codes in IDLE: 8-bit counter counts, 2-bit saturates.
    step(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 4'b0101, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 1, 4'b1010, 0, 0, 0, 0, 1, 2, 0);
    step(0, 0, 1, 4'b0100, 0, 0, 0, 0, 1, 3, 0);
    step(0, 0, 1, 4'b1011, 0, 0, 0, 0, 1, 4, 0);
    step(0, 0, 1, 4'b1001, 0, 0, 0, 0, 1, 5, 0);

    // Illegal in TRACK drops back to IDLE; a legal code re-enters TRACK.
    step(0, 0, 1, jc[0],   0, 1, 0, 0, 0, 5, 0);
    step(0, 0, 1, jc[1],   1, 1, 0, 0, 0, 5, 0);
    step(0, 0, 1, 4'b0110, 1, 0, 0, 0, 1, 6, 0);
    step(0, 0, 1, jc[5],   5, 1, 0, 0, 0, 6, 0);

    // rst + clr + en on an illegal code: reset values, no err.
    step(1, 1, 1, 4'b0110, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
